map_taito_x1: RTL and testbench

Parametrised Taito X1-series mapper core covering X1-005 (iNES 80), X1-005 with CHR-driven mirroring (iNES 207) and X1-017 (iNES 82) in one block. It decodes CPU register writes in $7EF0–$7EFF, holds the PRG/CHR bank, mirroring and RAM-protect state, and produces PRG/CHR/SRAM/CIRAM addressing for the cartridge bus. It sits in the mapper slot, and its bank state is fully exposed to the save-state controller.

---
 rtl/taito_x1_pkg.sv | 51 +++++
 rtl/taito_x1_regs.sv | 132 +++++++++++++
 rtl/map_taito_x1.sv | 110 +++++++++++
 tb/tb_map_taito_x1.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taito_x1_pkg.sv
// Shared definitions for the Taito X1-005 / X1-017 mapper core: variant codes,
// SRAM unlock keys, save-state indices, register file layout and window decode.
package taito_x1_pkg;

    localparam int VAR_X1005     = 0;   // iNES 80
    localparam int VAR_X1005_MIR = 1;   // iNES 207, mirroring taken from the CHR registers
    localparam int VAR_X1017     = 2;   // iNES 82

    localparam logic [7:0] KEY_X1005   = 8'hA3;
    localparam logic [7:0] KEY_X1017_0 = 8'hCA;
    localparam logic [7:0] KEY_X1017_1 = 8'h69;
    localparam logic [7:0] KEY_X1017_2 = 8'h84;

    localparam logic [7:0] SS_IDX_CHR2    = 8'd0;
    localparam logic [7:0] SS_IDX_CHR1    = 8'd2;
    localparam logic [7:0] SS_IDX_PRG     = 8'd6;
    localparam logic [7:0] SS_IDX_FLAGS   = 8'd9;
    localparam logic [7:0] SS_IDX_KEY     = 8'd10;
    localparam logic [7:0] SS_IDX_LAST    = 8'd12;
    localparam logic [7:0] SS_IDX_VARIANT = 8'd127;

    // Complete mapper state; chr2 entries are 1 KB bank numbers with bit0 forced low
    typedef struct packed {
        logic [1:0][7:0] chr2;
        logic [3:0][7:0] chr1;
        logic [2:0][7:0] prg;
        logic [2:0][7:0] ram_key;
        logic [1:0]      mir207;
        logic            mir_mode;
        logic            chr_inv;
    } regs_t;

    // Unlock value that opens X1-017 SRAM window idx
    function automatic logic [7:0] x1017_key(input int idx);
        case (idx)
            0:       return KEY_X1017_0;
            1:       return KEY_X1017_1;
            default: return KEY_X1017_2;
        endcase
    endfunction

    // X1-017 SRAM windows: $6000-$67FF, $6800-$6FFF, $7000-$73FF
    function automatic logic x1017_win(input int idx, input logic [15:0] a);
        case (idx)
            0:       return a[15:11] == 5'b01100;
            1:       return a[15:11] == 5'b01101;
            default: return a[15:10] == 6'b011100;
        endcase
    endfunction

endpackage

// File: rtl/taito_x1_regs.sv
// Register file of the X1 mapper: CPU write decode at $7EF0-$7EFF for both chip
// families, plus the save-state restore/readback path. During save-state mode
// the CPU data bus carries the restore data and CPU register writes are blocked.
module taito_x1_regs
    import taito_x1_pkg::*;
#(
    parameter int VARIANT = 0
) (
    input  logic        i_m2,
    input  logic        i_rst,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_dat,
    input  logic        i_cpu_rw,
    input  logic        i_ss_act,
    input  logic        i_ss_we,
    input  logic [7:0]  i_ss_addr,
    output logic [7:0]  o_ss_rdat,
    output regs_t       o_regs
);

    regs_t            r_regs;
    regs_t            w_regs_next;
    logic             w_cpu_wr;
    logic [3:0]       w_reg_sel;
    logic [12:0][7:0] w_ss_file;

    assign w_cpu_wr  = !i_ss_act && !i_cpu_rw && (i_cpu_addr[15:4] == 12'h7EF);
    assign w_reg_sel = i_cpu_addr[3:0];
    assign o_regs    = r_regs;

    // Next state: save-state restore has priority, otherwise decode CPU register writes
    always_comb begin
        w_regs_next = r_regs;
        if (i_ss_act) begin
            if (i_ss_we) begin
                case (i_ss_addr)
                    8'd0:  w_regs_next.chr2[0]    = i_cpu_dat;
                    8'd1:  w_regs_next.chr2[1]    = i_cpu_dat;
                    8'd2:  w_regs_next.chr1[0]    = i_cpu_dat;
                    8'd3:  w_regs_next.chr1[1]    = i_cpu_dat;
                    8'd4:  w_regs_next.chr1[2]    = i_cpu_dat;
                    8'd5:  w_regs_next.chr1[3]    = i_cpu_dat;
                    8'd6:  w_regs_next.prg[0]     = i_cpu_dat;
                    8'd7:  w_regs_next.prg[1]     = i_cpu_dat;
                    8'd8:  w_regs_next.prg[2]     = i_cpu_dat;
                    8'd9: begin
                        w_regs_next.mir_mode = i_cpu_dat[0];
                        w_regs_next.mir207   = i_cpu_dat[2:1];
                        w_regs_next.chr_inv  = (VARIANT == VAR_X1017) ? i_cpu_dat[3] : 1'b0;
                    end
                    8'd10: w_regs_next.ram_key[0] = i_cpu_dat;
                    8'd11: w_regs_next.ram_key[1] = i_cpu_dat;
                    8'd12: w_regs_next.ram_key[2] = i_cpu_dat;
                    default: ;
                endcase
            end
        end else if (w_cpu_wr) begin
            if (VARIANT == VAR_X1017) begin
                case (w_reg_sel)
                    4'h0, 4'h1: w_regs_next.chr2[w_reg_sel[0]] = {i_cpu_dat[7:1], 1'b0};
                    4'h2: w_regs_next.chr1[0] = i_cpu_dat;
                    4'h3: w_regs_next.chr1[1] = i_cpu_dat;
                    4'h4: w_regs_next.chr1[2] = i_cpu_dat;
                    4'h5: w_regs_next.chr1[3] = i_cpu_dat;
                    4'h6: begin
                        w_regs_next.mir_mode = i_cpu_dat[0];
                        w_regs_next.chr_inv  = i_cpu_dat[1];
                    end
                    4'h7: w_regs_next.ram_key[0] = i_cpu_dat;
                    4'h8: w_regs_next.ram_key[1] = i_cpu_dat;
                    4'h9: w_regs_next.ram_key[2] = i_cpu_dat;
                    4'hA: w_regs_next.prg[0] = {4'b0, i_cpu_dat[5:2]};
                    4'hB: w_regs_next.prg[1] = {4'b0, i_cpu_dat[5:2]};
                    4'hC: w_regs_next.prg[2] = {4'b0, i_cpu_dat[5:2]};
                    default: ;
                endcase
            end else begin
                case (w_reg_sel)
                    4'h0, 4'h1: begin
                        w_regs_next.chr2[w_reg_sel[0]]   = {1'b0, i_cpu_dat[6:1], 1'b0};
                        w_regs_next.mir207[w_reg_sel[0]] = i_cpu_dat[7];
                    end
                    4'h2: w_regs_next.chr1[0] = {1'b0, i_cpu_dat[6:0]};
                    4'h3: w_regs_next.chr1[1] = {1'b0, i_cpu_dat[6:0]};
                    4'h4: w_regs_next.chr1[2] = {1'b0, i_cpu_dat[6:0]};
                    4'h5: w_regs_next.chr1[3] = {1'b0, i_cpu_dat[6:0]};
                    4'h6, 4'h7: w_regs_next.mir_mode   = i_cpu_dat[0];
                    4'h8, 4'h9: w_regs_next.ram_key[0] = i_cpu_dat;
                    4'hA, 4'hB: w_regs_next.prg[0] = {3'b0, i_cpu_dat[4:0]};
                    4'hC, 4'hD: w_regs_next.prg[1] = {3'b0, i_cpu_dat[4:0]};
                    4'hE, 4'hF: w_regs_next.prg[2] = {3'b0, i_cpu_dat[4:0]};
                endcase
            end
        end
    end

    // State register; reset is ignored in save-state mode so a restore is not clobbered
    always_ff @(negedge i_m2) begin
        if (i_rst && !i_ss_act) begin
            r_regs <= '0;
        end else begin
            r_regs <= w_regs_next;
        end
    end

    // Flatten the register file into save-state index order
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ss_chr2
            assign w_ss_file[gi] = r_regs.chr2[gi];
        end
        for (gi = 0; gi < 4; gi++) begin : g_ss_chr1
            assign w_ss_file[2 + gi] = r_regs.chr1[gi];
        end
        for (gi = 0; gi < 3; gi++) begin : g_ss_prg_key
            assign w_ss_file[6 + gi]  = r_regs.prg[gi];
            assign w_ss_file[10 + gi] = r_regs.ram_key[gi];
        end
    endgenerate
    assign w_ss_file[9] = {4'b0, r_regs.chr_inv, r_regs.mir207, r_regs.mir_mode};

    // Save-state readback; unmapped indices read as all-ones
    always_comb begin
        o_ss_rdat = 8'hFF;
        if (i_ss_addr <= SS_IDX_LAST) begin
            o_ss_rdat = w_ss_file[i_ss_addr[3:0]];
        end else if (i_ss_addr == SS_IDX_VARIANT) begin
            o_ss_rdat = 8'(VARIANT);
        end
    end

endmodule

// File: rtl/map_taito_x1.sv
// Taito X1-series mapper top: PRG/CHR banking, nametable mirroring and SRAM
// protection for X1-005 (80), X1-005 with CHR-driven mirroring (207) and X1-017 (82).
module map_taito_x1
    import taito_x1_pkg::*;
#(
    parameter int VARIANT  = 0,
    parameter int PRG_BITS = 5,
    parameter int CHR_BITS = 8
) (
    input  logic                  m2,
    input  logic                  map_rst,
    input  logic [15:0]           cpu_addr,
    input  logic [7:0]            cpu_dat,
    input  logic                  cpu_rw,
    input  logic [13:0]           ppu_addr,
    input  logic                  ss_act,
    input  logic                  ss_we,
    input  logic [7:0]            ss_addr,
    output logic [7:0]            ss_rdat,
    output logic [PRG_BITS+12:0]  prg_addr,
    output logic [CHR_BITS+9:0]   chr_addr,
    output logic                  rom_ce,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [12:0]           srm_addr,
    output logic                  ciram_a10,
    output logic                  ciram_ce
);

    regs_t                w_regs;
    logic [PRG_BITS-1:0]  w_prg_bank;
    logic                 w_pa12;
    logic [7:0]           w_chr_bank;
    logic [2:0]           w_win_open;
    logic                 w_unused_regs;

    taito_x1_regs #(
        .VARIANT(VARIANT)
    ) u_regs (
        .i_m2       (m2),
        .i_rst      (map_rst),
        .i_cpu_addr (cpu_addr),
        .i_cpu_dat  (cpu_dat),
        .i_cpu_rw   (cpu_rw),
        .i_ss_act   (ss_act),
        .i_ss_we    (ss_we),
        .i_ss_addr  (ss_addr),
        .o_ss_rdat  (ss_rdat),
        .o_regs     (w_regs)
    );

    // Not every register bit reaches an output for every variant/width
    assign w_unused_regs = ^w_regs;

    assign rom_ce   = cpu_addr[15];
    assign ciram_ce = !ppu_addr[13];

    // PRG bank per 8 KB slot; $E000 is fixed to the last bank
    always_comb begin
        case (cpu_addr[14:13])
            2'd0:    w_prg_bank = PRG_BITS'(w_regs.prg[0]);
            2'd1:    w_prg_bank = PRG_BITS'(w_regs.prg[1]);
            2'd2:    w_prg_bank = PRG_BITS'(w_regs.prg[2]);
            default: w_prg_bank = '1;
        endcase
    end
    assign prg_addr = {w_prg_bank, cpu_addr[12:0]};

    // CHR: one half of pattern space uses 2 KB banks, the other 1 KB banks; chr_inv swaps halves
    assign w_pa12 = ppu_addr[12] ^ w_regs.chr_inv;
    always_comb begin
        if (!w_pa12) begin
            w_chr_bank = {w_regs.chr2[ppu_addr[11]][7:1], ppu_addr[10]};
        end else begin
            w_chr_bank = w_regs.chr1[ppu_addr[11:10]];
        end
    end
    assign chr_addr = {CHR_BITS'(w_chr_bank), ppu_addr[9:0]};

    // Nametable select: per-half bits for 207, else vertical/horizontal switch
    always_comb begin
        if (VARIANT == VAR_X1005_MIR) begin
            ciram_a10 = w_regs.mir207[ppu_addr[11]];
        end else begin
            ciram_a10 = w_regs.mir_mode ? ppu_addr[10] : ppu_addr[11];
        end
    end

    // X1-017 windows, each unlocked by its own key register
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win
            assign w_win_open[gi] = x1017_win(gi, cpu_addr) &&
                                    (w_regs.ram_key[gi] == x1017_key(gi));
        end
    endgenerate

    // SRAM select and address; X1-005 exposes 128 bytes mirrored over $7F00-$7FFF
    always_comb begin
        if (VARIANT == VAR_X1017) begin
            ram_ce   = |w_win_open;
            srm_addr = cpu_addr[12:0];
        end else begin
            ram_ce   = (cpu_addr[15:8] == 8'h7F) && (w_regs.ram_key[0] == KEY_X1005);
            srm_addr = {6'b0, cpu_addr[6:0]};
        end
    end
    assign ram_we = ram_ce & ~cpu_rw;

endmodule

// File: tb/tb_map_taito_x1.sv
// Scoreboard bench for map_taito_x1: all three variants run side by side on the
// same bus; a behavioural model predicts every output of every transaction.
`timescale 1ns/1ps
module tb_map_taito_x1;

    logic        m2       = 1'b0;
    logic        map_rst  = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_dat  = 8'h0;
    logic        cpu_rw   = 1'b1;
    logic [13:0] ppu_addr = 14'h0;
    logic        ss_act   = 1'b0;
    logic        ss_we    = 1'b0;
    logic [7:0]  ss_addr  = 8'h0;

    logic [7:0]  ss_rdat_o [3];
    logic [17:0] prg_o     [3];
    logic [17:0] chr_o     [3];
    logic        rom_ce_o  [3];
    logic        ram_ce_o  [3];
    logic        ram_we_o  [3];
    logic [12:0] srm_o     [3];
    logic        a10_o     [3];
    logic        cce_o     [3];

    always #5 m2 = ~m2;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_dut
        map_taito_x1 #(
            .VARIANT(gi), .PRG_BITS(5), .CHR_BITS(8)
        ) u_dut (
            .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
            .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .ss_act(ss_act), .ss_we(ss_we),
            .ss_addr(ss_addr), .ss_rdat(ss_rdat_o[gi]), .prg_addr(prg_o[gi]),
            .chr_addr(chr_o[gi]), .rom_ce(rom_ce_o[gi]), .ram_ce(ram_ce_o[gi]),
            .ram_we(ram_we_o[gi]), .srm_addr(srm_o[gi]), .ciram_a10(a10_o[gi]),
            .ciram_ce(cce_o[gi])
        );
    end

    typedef struct packed {
        logic [17:0] prg;
        logic [17:0] chr;
        logic        rom_ce;
        logic        ram_ce;
        logic        ram_we;
        logic [12:0] srm;
        logic        a10;
        logic        cce;
        logic [7:0]  ss;
    } exp_t;

    typedef struct packed {
        logic [15:0]     a;
        logic [7:0]      d;
        logic            rw;
        logic [13:0]     p;
        logic            sa;
        logic [7:0]      si;
        logic [2:0]      kind;
        exp_t [2:0]      v;
    } txn_t;

    txn_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_txn = 0;
    int   keys[4] = '{'hA3, 'hCA, 'h69, 'h84};

    // Behavioural model state, one copy per variant
    int m_chr2[3][2], m_chr1[3][4], m_prg[3][3], m_key[3][3], m_mir207[3][2];
    int m_mir[3], m_inv[3];

    function automatic void m_clear();
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 4; i++) m_chr1[v][i] = 0;
            for (int i = 0; i < 2; i++) begin m_chr2[v][i] = 0; m_mir207[v][i] = 0; end
            for (int i = 0; i < 3; i++) begin m_prg[v][i] = 0; m_key[v][i] = 0; end
            m_mir[v] = 0;
            m_inv[v] = 0;
        end
    endfunction

    function automatic void m_cpu_write(int v, int a, int d);
        int r;
        r = a % 16;
        if (a / 16 != 'h7EF) return;
        if (v == 2) begin
            if (r < 2)       m_chr2[v][r] = d & 'hFE;
            else if (r < 6)  m_chr1[v][r-2] = d;
            else if (r == 6) begin m_mir[v] = d % 2; m_inv[v] = (d / 2) % 2; end
            else if (r < 10) m_key[v][r-7] = d;
            else if (r < 13) m_prg[v][r-10] = (d / 4) % 16;
        end else begin
            if (r < 2)       begin m_chr2[v][r] = d & 'h7E; m_mir207[v][r] = d / 128; end
            else if (r < 6)  m_chr1[v][r-2] = d % 128;
            else if (r < 8)  m_mir[v] = d % 2;
            else if (r < 10) m_key[v][0] = d;
            else             m_prg[v][(r-10)/2] = d % 32;
        end
    endfunction

    function automatic void m_ss_write(int v, int i, int d);
        if (i < 2)       m_chr2[v][i] = d;
        else if (i < 6)  m_chr1[v][i-2] = d;
        else if (i < 9)  m_prg[v][i-6] = d;
        else if (i == 9) begin
            m_mir[v]       = d % 2;
            m_mir207[v][0] = (d / 2) % 2;
            m_mir207[v][1] = (d / 4) % 2;
            m_inv[v]       = (v == 2) ? (d / 8) % 2 : 0;
        end
        else if (i < 13) m_key[v][i-10] = d;
    endfunction

    function automatic int m_ss_read(int v, int i);
        if (i < 2)    return m_chr2[v][i];
        if (i < 6)    return m_chr1[v][i-2];
        if (i < 9)    return m_prg[v][i-6];
        if (i == 9)   return m_inv[v]*8 + m_mir207[v][1]*4 + m_mir207[v][0]*2 + m_mir[v];
        if (i < 13)   return m_key[v][i-10];
        if (i == 127) return v;
        return 255;
    endfunction

    function automatic exp_t m_expect(int v, int a, int p, int rw, int si);
        exp_t e;
        int   bank;
        int   slot;
        slot  = (a / 8192) % 4;
        bank  = (slot == 3) ? 31 : m_prg[v][slot] % 32;
        e.prg = 18'(bank * 8192 + a % 8192);
        if ((p / 4096) % 2 != m_inv[v]) bank = m_chr1[v][(p / 1024) % 4];
        else bank = (m_chr2[v][(p / 2048) % 2] & 'hFE) + (p / 1024) % 2;
        e.chr    = 18'((bank % 256) * 1024 + p % 1024);
        e.rom_ce = (a >= 'h8000);
        e.cce    = (p < 'h2000);
        if (v == 1) e.a10 = 1'(m_mir207[v][(p / 2048) % 2]);
        else        e.a10 = 1'((m_mir[v] != 0) ? (p / 1024) % 2 : (p / 2048) % 2);
        if (v == 2) begin
            e.ram_ce = (a >= 'h6000 && a < 'h6800 && m_key[v][0] == 'hCA) ||
                       (a >= 'h6800 && a < 'h7000 && m_key[v][1] == 'h69) ||
                       (a >= 'h7000 && a < 'h7400 && m_key[v][2] == 'h84);
            e.srm    = 13'(a % 8192);
        end else begin
            e.ram_ce = (a >= 'h7F00 && a <= 'h7FFF && m_key[v][0] == 'hA3);
            e.srm    = 13'(a % 128);
        end
        e.ram_we = e.ram_ce && (rw == 0);
        e.ss     = 8'(m_ss_read(v, si));
        return e;
    endfunction

    // Drive one bus cycle, advance the model, push the predicted outputs
    task automatic step(input int rst, input int a, input int d, input int rw,
                        input int p, input int sa, input int sw, input int si);
        txn_t t;
        @(posedge m2);
        #2;
        map_rst  = 1'(rst);
        cpu_addr = 16'(a);
        cpu_dat  = 8'(d);
        cpu_rw   = 1'(rw);
        ppu_addr = 14'(p);
        ss_act   = 1'(sa);
        ss_we    = 1'(sw);
        ss_addr  = 8'(si);
        if (sa != 0) begin
            if (sw != 0) for (int v = 0; v < 3; v++) m_ss_write(v, si, d);
        end else if (rst != 0) begin
            m_clear();
        end else if (rw == 0) begin
            for (int v = 0; v < 3; v++) m_cpu_write(v, a, d);
        end
        t.a  = 16'(a);
        t.d  = 8'(d);
        t.rw = 1'(rw);
        t.p  = 14'(p);
        t.sa = 1'(sa);
        t.si = 8'(si);
        t.kind = {1'(rst), 1'(sw), 1'(sa)};
        for (int v = 0; v < 3; v++) t.v[v] = m_expect(v, a, p, rw, si);
        exp_q.push_back(t);
    endtask

    function automatic void chk(int v, int idx, string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL txn %0d variant %0d %s: got %h expected %h", idx, v, name, act, exp);
        end
    endfunction

    // Monitor: outputs settle after the negedge update; compare on the following posedge
    always @(posedge m2) begin
        txn_t t;
        if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            $display("txn %0d cpu=%h d=%h rw=%b ppu=%h ss_act=%b ss_idx=%0d rst/we/act=%b",
                     n_txn, t.a, t.d, t.rw, t.p, t.sa, t.si, t.kind);
            for (int v = 0; v < 3; v++) begin
                chk(v, n_txn, "prg_addr",  32'(prg_o[v]),     32'(t.v[v].prg));
                chk(v, n_txn, "chr_addr",  32'(chr_o[v]),     32'(t.v[v].chr));
                chk(v, n_txn, "rom_ce",    32'(rom_ce_o[v]),  32'(t.v[v].rom_ce));
                chk(v, n_txn, "ram_ce",    32'(ram_ce_o[v]),  32'(t.v[v].ram_ce));
                chk(v, n_txn, "ram_we",    32'(ram_we_o[v]),  32'(t.v[v].ram_we));
                chk(v, n_txn, "srm_addr",  32'(srm_o[v]),     32'(t.v[v].srm));
                chk(v, n_txn, "ciram_a10", 32'(a10_o[v]),     32'(t.v[v].a10));
                chk(v, n_txn, "ciram_ce",  32'(cce_o[v]),     32'(t.v[v].cce));
                chk(v, n_txn, "ss_rdat",   32'(ss_rdat_o[v]), 32'(t.v[v].ss));
            end
            n_txn++;
        end
    end

    initial begin
        int kind, a, d, p, rw, sa, sw, si, rst;
        m_clear();

        // Reset and reset-state readback
        step(1, 'h8000, 0, 1, 'h0000, 0, 0, 0);
        step(1, 'h8000, 0, 1, 'h1C00, 0, 0, 9);
        step(0, 'h8000, 0, 1, 'h0400, 1, 0, 127);
        step(0, 'h6000, 0, 1, 'h2C00, 0, 0, 200);

        // PRG banking and fixed last bank
        step(0, 'h7EFA, 'h05, 0, 0, 0, 0, 6);
        step(0, 'h8123, 0, 1, 0, 0, 0, 6);
        step(0, 'hE000, 0, 1, 0, 0, 0, 6);

        // X1-005 SRAM key
        step(0, 'h7EF8, 'hA3, 0, 0, 0, 0, 10);
        step(0, 'h7F85, 'h5A, 0, 0, 0, 0, 10);
        step(0, 'h7EFF, 'h1F, 0, 0, 0, 0, 10);
        step(0, 'h7EF8, 'hA2, 0, 0, 0, 0, 10);
        step(0, 'h7F85, 'h5A, 0, 0, 0, 0, 10);

        // X1-017 SRAM windows and PRG encoding
        step(0, 'h7EF7, 'hCA, 0, 0, 0, 0, 10);
        step(0, 'h6010, 0, 1, 0, 0, 0, 10);
        step(0, 'h6810, 0, 1, 0, 0, 0, 11);
        step(0, 'h7010, 0, 1, 0, 0, 0, 12);
        step(0, 'h7EFB, 'h14, 0, 0, 0, 0, 7);
        step(0, 'hA000, 0, 1, 0, 0, 0, 7);
        step(0, 'h7EF8, 'h69, 0, 0, 0, 0, 11);
        step(0, 'h7EF9, 'h84, 0, 0, 0, 0, 12);
        step(0, 'h67FF, 'h11, 0, 0, 0, 0, 12);
        step(0, 'h6800, 'h11, 0, 0, 0, 0, 12);
        step(0, 'h73FF, 0, 1, 0, 0, 0, 12);
        step(0, 'h7400, 0, 1, 0, 0, 0, 12);
        step(0, 'h7EEF, 0, 1, 0, 0, 0, 12);

        // CHR inversion
        step(0, 'h7EF6, 'h02, 0, 0, 0, 0, 9);
        step(0, 'h7EF2, 'h33, 0, 'h0000, 0, 0, 2);
        step(0, 'h0000, 0, 1, 'h0000, 0, 0, 2);
        step(0, 'h0000, 0, 1, 'h1C00, 0, 0, 2);

        // 207 mirroring
        step(0, 'h7EF0, 'h80, 0, 0, 0, 0, 0);
        step(0, 'h7EF1, 'h00, 0, 0, 0, 0, 1);
        step(0, 'h0000, 0, 1, 'h2000, 0, 0, 9);
        step(0, 'h0000, 0, 1, 'h2800, 0, 0, 9);

        // Save state: restore, blocked CPU write, reset immunity, ignored ss_we
        step(0, 'h0000, 'h07, 1, 0, 1, 1, 6);
        step(0, 'h7EFA, 'h01, 0, 0, 1, 0, 6);
        step(1, 'h8000, 'h00, 1, 0, 1, 0, 6);
        step(0, 'h8000, 'h55, 1, 0, 0, 1, 6);
        step(0, 'h0000, 'h0F, 1, 0, 1, 1, 9);
        step(0, 'h0000, 0, 1, 'h0000, 0, 0, 9);

        // Reset wins over a simultaneous register write
        step(1, 'h7EFA, 'h09, 0, 0, 0, 0, 6);
        step(0, 'h8000, 0, 1, 0, 0, 0, 6);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom_range(0, 65535);
            d    = $urandom_range(0, 255);
            p    = $urandom_range(0, 16383);
            rw   = $urandom_range(0, 1);
            sa   = 0;
            sw   = 0;
            rst  = 0;
            si   = $urandom_range(0, 15);
            if (si == 13) si = 127;
            case (kind)
                0, 1, 2, 3: begin
                    a  = 'h7EF0 + $urandom_range(0, 15);
                    rw = 0;
                    if ($urandom_range(0, 2) == 0) d = keys[$urandom_range(0, 3)];
                end
                4, 5: a = 'h6000 + $urandom_range(0, 8191);
                6:    a = 'h7F00 + $urandom_range(0, 255);
                7: begin
                    sa  = 1;
                    sw  = $urandom_range(0, 1);
                    rst = $urandom_range(0, 1);
                end
                8: if ($urandom_range(0, 7) == 0) rst = 1;
                default: ;
            endcase
            step(rst, a, d, rw, p, sa, sw, si);
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge m2);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d transactions pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
